// File: rtl/coin_event_arbiter_pkg.sv
// Shared types and constants for the coin event arbiter: FSM states, pend bit
// indices, default timing parameters and the fixed-priority selector.
package coin_event_arbiter_pkg;

    localparam int unsigned NUM_BTN = 3;
    localparam int unsigned FIFTY   = 0;
    localparam int unsigned DOLLAR  = 1;
    localparam int unsigned CANCEL  = 2;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_GAP_CYCLES      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // One-hot pick of the highest-priority pending event: cancel > dollar > fifty.
    function automatic logic [NUM_BTN-1:0] pick_highest(input logic [NUM_BTN-1:0] p);
        pick_highest = '0;
        if (p[CANCEL])      pick_highest[CANCEL] = 1'b1;
        else if (p[DOLLAR]) pick_highest[DOLLAR] = 1'b1;
        else if (p[FIFTY])  pick_highest[FIFTY]  = 1'b1;
    endfunction

endpackage

// File: rtl/coin_event_arbiter_if.sv
// Button-side and FSM-side signals of the coin event arbiter.
interface coin_event_arbiter_if;
    import coin_event_arbiter_pkg::*;

    logic               fifty_btn;
    logic               dollar_btn;
    logic               cancel_btn;
    logic               fsm_busy;
    logic               overrun_clr;
    logic               fifty_p;
    logic               dollar_p;
    logic               cancel_p;
    logic [NUM_BTN-1:0] pend;
    logic               overrun;

    modport master (
        output fifty_btn, dollar_btn, cancel_btn, fsm_busy, overrun_clr,
        input  fifty_p, dollar_p, cancel_p, pend, overrun
    );

    modport slave (
        input  fifty_btn, dollar_btn, cancel_btn, fsm_busy, overrun_clr,
        output fifty_p, dollar_p, cancel_p, pend, overrun
    );

endinterface

// File: rtl/coin_event_arbiter_btn_debounce.sv
// One raw button: 2-flop synchronizer, stability counter, registered
// one-cycle event on each accepted rising level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic evt
);

    localparam int unsigned CW       = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LAST_INT = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(LAST_INT);

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          evt_q;
    logic          flip;

    // Level flips on the last of the required consecutive disagreeing cycles.
    assign flip = (sync_q[1] != level_q) && (cnt_q == CNT_LAST);
    assign evt  = evt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            evt_q  <= flip & sync_q[1];
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (flip) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/coin_event_arbiter.sv
// Debounces the three buttons, latches presses as pending events and issues
// them to the vending FSM one at a time as single-cycle pulses.
module coin_event_arbiter #(
    parameter int unsigned DEBOUNCE_CYCLES = coin_event_arbiter_pkg::DEF_DEBOUNCE_CYCLES,
    parameter int unsigned GAP_CYCLES      = coin_event_arbiter_pkg::DEF_GAP_CYCLES
) (
    input logic              clk,
    input logic              rst,
    coin_event_arbiter_if.slave bus
);
    import coin_event_arbiter_pkg::*;

    localparam int unsigned GW       = ($clog2(GAP_CYCLES + 1) < 1) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam int unsigned GAP_LAST_INT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_INT);

    logic [NUM_BTN-1:0] evt;
    logic [NUM_BTN-1:0] sel;
    state_e             state_q, state_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [NUM_BTN-1:0] pulse_q, pulse_d;
    logic               overrun_q, overrun_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fifty (
        .clk(clk), .rst(rst), .btn(bus.fifty_btn),  .evt(evt[FIFTY])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dollar (
        .clk(clk), .rst(rst), .btn(bus.dollar_btn), .evt(evt[DOLLAR])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
        .clk(clk), .rst(rst), .btn(bus.cancel_btn), .evt(evt[CANCEL])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            pend_q    <= '0;
            pulse_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            pend_q    <= pend_d;
            pulse_q   <= pulse_d;
            overrun_q <= overrun_d;
        end
    end

    // Next state; the pulse is registered on the IDLE->ISSUE decision so it is high in ISSUE.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        pulse_d   = '0;
        sel       = '0;
        case (state_q)
            ST_IDLE: begin
                if ((pend_q != '0) && !bus.fsm_busy) begin
                    sel     = pick_highest(pend_q);
                    pulse_d = sel;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                gap_cnt_d = '0;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
                else                       gap_cnt_d = gap_cnt_q + GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // A new event beats the clear of its own bit, so re-presses during issue are kept.
        pend_d = (pend_q & ~sel) | evt;
        if ((evt & pend_q & ~sel) != '0) overrun_d = 1'b1;
        else if (bus.overrun_clr)        overrun_d = 1'b0;
        else                             overrun_d = overrun_q;
    end

    assign bus.fifty_p  = pulse_q[FIFTY];
    assign bus.dollar_p = pulse_q[DOLLAR];
    assign bus.cancel_p = pulse_q[CANCEL];
    assign bus.pend     = pend_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_coin_event_arbiter.sv
// Self-checking bench for coin_event_arbiter: directed scenarios plus random
// button/busy/clear traffic, compared every cycle against a behavioural model.
module tb_coin_event_arbiter;

    localparam int DEB = 4;
    localparam int GAP = 2;
    localparam int GAP_EFF = (GAP == 0) ? 1 : GAP;

    logic clk = 1'b0;
    logic rst = 1'b1;

    coin_event_arbiter_if bus();

    coin_event_arbiter #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural model: raw->synced delay line, window of synced samples,
    // pending set, and a cooldown count of edges during which no issue may happen.
    bit [2:0] m_s1, m_s2, m_lvl, m_evt, m_pend, m_pulse;
    bit       m_ovr;
    int       m_hold;
    bit [7:0] m_hist [3];

    int pulse_cnt [3];
    int first_fifty;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit [2:0] highest(input bit [2:0] p);
        if (p[2])      return 3'b100;
        else if (p[1]) return 3'b010;
        else if (p[0]) return 3'b001;
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_evt = '0; m_pend = '0; m_pulse = '0;
        m_ovr = 1'b0; m_hold = 0;
        for (int b = 0; b < 3; b++) m_hist[b] = '0;
    endtask

    task automatic model_edge(input bit [2:0] raw, input bit busy, input bit clr, input bit r);
        bit [2:0] sel, new_evt;
        bit all_diff;
        if (r) begin
            model_reset();
            return;
        end
        sel = '0;
        if (m_hold > 0) m_hold--;
        else if (m_pend != 0 && !busy) begin
            sel    = highest(m_pend);
            m_hold = GAP_EFF + 1;
        end
        m_pulse = sel;
        if ((m_evt & m_pend & ~sel) != 0) m_ovr = 1'b1;
        else if (clr)                     m_ovr = 1'b0;
        m_pend = (m_pend & ~sel) | m_evt;
        new_evt = '0;
        for (int b = 0; b < 3; b++) begin
            m_hist[b] = {m_hist[b][6:0], m_s2[b]};
            all_diff = 1'b1;
            for (int k = 0; k < DEB; k++)
                if (m_hist[b][k] == m_lvl[b]) all_diff = 1'b0;
            if (all_diff) begin
                m_lvl[b]   = ~m_lvl[b];
                new_evt[b] = m_lvl[b];
            end
        end
        m_evt = new_evt;
        m_s2  = m_s1;
        m_s1  = raw;
    endtask

    task automatic tick();
        bit [2:0] raw;
        bit busy, clr, r;
        bit [2:0] p;
        raw  = {bus.cancel_btn, bus.dollar_btn, bus.fifty_btn};
        busy = bus.fsm_busy;
        clr  = bus.overrun_clr;
        r    = rst;
        @(posedge clk);
        model_edge(raw, busy, clr, r);
        #1;
        p = {bus.cancel_p, bus.dollar_p, bus.fifty_p};
        check("pulse",   8'(p),           8'(m_pulse));
        check("pend",    8'(bus.pend),    8'(m_pend));
        check("overrun", 8'(bus.overrun), 8'(m_ovr));
        for (int b = 0; b < 3; b++) if (p[b]) pulse_cnt[b]++;
        if (bus.fifty_p && first_fifty < 0) first_fifty = cyc;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        for (int b = 0; b < 3; b++) pulse_cnt[b] = 0;
        first_fifty = -1;
    endtask

    task automatic set_btns(input bit [2:0] v);
        bus.fifty_btn  = v[0];
        bus.dollar_btn = v[1];
        bus.cancel_btn = v[2];
    endtask

    initial begin
        int press_cyc;
        model_reset();
        set_btns(3'b000);
        bus.fsm_busy    = 1'b0;
        bus.overrun_clr = 1'b0;
        rst = 1'b1;
        ticks(3);
        check("reset_pend",    8'(bus.pend), 8'h00);
        check("reset_overrun", 8'(bus.overrun), 8'h00);
        check("reset_pulses",  8'({bus.cancel_p, bus.dollar_p, bus.fifty_p}), 8'h00);
        rst = 1'b0;
        ticks(2);

        // Clean fifty press
        clear_counts();
        press_cyc = cyc;
        set_btns(3'b001);
        ticks(10);
        set_btns(3'b000);
        ticks(15);
        check("t1_fifty_count", 8'(pulse_cnt[0]), 8'd1);
        check("t1_latency", 8'(first_fifty - press_cyc), 8'd7);
        check("t1_pend_empty", 8'(bus.pend), 8'h00);

        // Bouncy dollar
        clear_counts();
        set_btns(3'b010); tick();
        set_btns(3'b000); tick();
        set_btns(3'b010); tick();
        set_btns(3'b000); tick();
        set_btns(3'b010); ticks(10);
        set_btns(3'b000); ticks(15);
        check("t2_dollar_count", 8'(pulse_cnt[1]), 8'd1);

        // Simultaneous presses
        clear_counts();
        set_btns(3'b111); ticks(8);
        set_btns(3'b000); ticks(25);
        check("t3_cancel_count", 8'(pulse_cnt[2]), 8'd1);
        check("t3_dollar_count", 8'(pulse_cnt[1]), 8'd1);
        check("t3_fifty_count",  8'(pulse_cnt[0]), 8'd1);

        // Busy holds a dollar
        clear_counts();
        bus.fsm_busy = 1'b1;
        set_btns(3'b010); ticks(8);
        set_btns(3'b000); ticks(15);
        check("t4_no_pulse_busy", 8'(pulse_cnt[1]), 8'd0);
        bus.fsm_busy = 1'b0;
        ticks(10);
        check("t4_dollar_after", 8'(pulse_cnt[1]), 8'd1);

        // Overrun: two fifty presses while busy, clear, coincident clear
        clear_counts();
        bus.fsm_busy = 1'b1;
        set_btns(3'b001); ticks(8);
        set_btns(3'b000); ticks(8);
        set_btns(3'b001); ticks(8);
        set_btns(3'b000); ticks(4);
        check("t5_overrun_set", 8'(bus.overrun), 8'd1);
        bus.fsm_busy = 1'b0;
        ticks(10);
        check("t5_one_fifty", 8'(pulse_cnt[0]), 8'd1);
        bus.overrun_clr = 1'b1; tick();
        bus.overrun_clr = 1'b0; tick();
        check("t5_overrun_clr", 8'(bus.overrun), 8'd0);
        bus.fsm_busy = 1'b1;
        set_btns(3'b001); ticks(8);
        set_btns(3'b000); ticks(4);
        bus.overrun_clr = 1'b1;
        set_btns(3'b001); ticks(12);
        bus.overrun_clr = 1'b0;
        set_btns(3'b000); ticks(4);
        bus.fsm_busy = 1'b0;
        ticks(10);

        // Reset during ISSUE
        clear_counts();
        bus.fsm_busy = 1'b1;
        set_btns(3'b111); ticks(8);
        set_btns(3'b000); ticks(4);
        bus.fsm_busy = 1'b0;
        for (int i = 0; i < 20 && !bus.cancel_p; i++) tick();
        check("t6_issue_seen", 8'(bus.cancel_p), 8'd1);
        rst = 1'b1; tick();
        check("t6_rst_pend",   8'(bus.pend), 8'h00);
        check("t6_rst_pulses", 8'({bus.cancel_p, bus.dollar_p, bus.fifty_p}), 8'h00);
        rst = 1'b0;
        clear_counts();
        ticks(20);
        check("t6_quiet", 8'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2]), 8'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) bus.fifty_btn  = ~bus.fifty_btn;
            if ($urandom_range(5) == 0) bus.dollar_btn = ~bus.dollar_btn;
            if ($urandom_range(5) == 0) bus.cancel_btn = ~bus.cancel_btn;
            if ($urandom_range(9) == 0) bus.fsm_busy   = ~bus.fsm_busy;
            bus.overrun_clr = ($urandom_range(7) == 0);
            rst = ($urandom_range(399) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
